// File: rtl/bsg_muxi2_arb_sched.sv
// Round-robin scheduler sharing one inverting per-bit 2:1 mux among els_p requesters.
// The result sits in a single-entry registered buffer with a valid/yumi handshake.
module bsg_muxi2_arb_sched #(
   parameter int unsigned width_p = 16,
   parameter int unsigned els_p   = 2,
   localparam int unsigned lg_els_lp = $clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] i0_i,
   input  logic [els_p*width_p-1:0] i1_i,
   input  logic [els_p*width_p-1:0] sel_i,
   output logic [els_p-1:0]         ready_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   output logic [lg_els_lp-1:0]     id_o,
   input  logic                     yumi_i
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e                 state_q, state_d;
   logic [width_p-1:0]     data_q, data_d;
   logic [lg_els_lp-1:0]   id_q, id_d;
   logic [lg_els_lp-1:0]   ptr_q, ptr_d;

   logic [2*els_p-1:0]     v_dbl;
   logic [2*els_p-1:0]     v_rot;
   logic                   found;
   logic [lg_els_lp:0]     sum;
   logic [lg_els_lp-1:0]   grant_id;
   logic [els_p-1:0]       grant;
   logic                   acc_en;
   logic                   xfer;
   logic [width_p-1:0]     i0_g, i1_g, sel_g;

   // Doubling the request vector lets a plain shift rotate it for any els_p.
   assign v_dbl = {v_i, v_i};
   assign v_rot = v_dbl >> ptr_q;

   always_comb begin
      found    = 1'b0;
      sum      = '0;
      grant_id = '0;
      grant    = '0;
      for (int j = 0; j < els_p; j++) begin
         if (!found && v_rot[j]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_q} + (lg_els_lp+1)'(j);
            if (sum >= (lg_els_lp+1)'(els_p)) begin
               sum = sum - (lg_els_lp+1)'(els_p);
            end
            grant_id = sum[lg_els_lp-1:0];
         end
      end
      grant[grant_id] = found;
   end

   assign acc_en  = (state_q == StEmpty) | yumi_i;
   assign xfer    = found & acc_en;
   assign ready_o = grant & {els_p{acc_en}};

   always_comb begin
      i0_g  = '0;
      i1_g  = '0;
      sel_g = '0;
      for (int k = 0; k < els_p; k++) begin
         i0_g  = i0_g  | (i0_i[k*width_p +: width_p]  & {width_p{grant[k]}});
         i1_g  = i1_g  | (i1_i[k*width_p +: width_p]  & {width_p{grant[k]}});
         sel_g = sel_g | (sel_i[k*width_p +: width_p] & {width_p{grant[k]}});
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         state_d = StFull;
         data_d  = ~((sel_g & i1_g) | (~sel_g & i0_g));
         id_d    = grant_id;
         ptr_d   = (grant_id == lg_els_lp'(els_p - 1)) ? '0 : grant_id + lg_els_lp'(1);
      end else if (yumi_i && (state_q == StFull)) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StEmpty;
         data_q  <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign v_o    = (state_q == StFull);
   assign data_o = data_q;
   assign id_o   = id_q;

endmodule

// File: tb/tb_bsg_muxi2_arb_sched.sv
// Directed bench for bsg_muxi2_arb_sched (width 16, two requesters): vector table plus
// hand-written reset, round-robin and mid-operation reset sequences.
module tb_bsg_muxi2_arb_sched;

   localparam int unsigned WidthP = 16;
   localparam int unsigned ElsP   = 2;

   // Operand triples packed as {i0, i1, sel}.
   localparam logic [47:0] OpA = {16'h00FF, 16'hFF00, 16'h0F0F}; // -> F00F
   localparam logic [47:0] OpB = {16'h0000, 16'h1234, 16'hFFFF}; // -> EDCB
   localparam logic [47:0] OpC = {16'hA5A5, 16'h0000, 16'h0000}; // -> 5A5A
   localparam logic [47:0] OpD = {16'h0000, 16'hFFFF, 16'h00FF}; // -> FF00
   localparam logic [47:0] OpZ = 48'h0;

   logic                    clk;
   logic                    reset_n;
   logic [ElsP-1:0]         v;
   logic [ElsP*WidthP-1:0]  i0, i1, sel;
   logic [ElsP-1:0]         ready;
   logic                    v_out;
   logic [WidthP-1:0]       data;
   logic                    id;
   logic                    yumi;

   int checks;
   int errors;

   bsg_muxi2_arb_sched #(
      .width_p (WidthP),
      .els_p   (ElsP)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .v_i       (v),
      .i0_i      (i0),
      .i1_i      (i1),
      .sel_i     (sel),
      .ready_o   (ready),
      .v_o       (v_out),
      .data_o    (data),
      .id_o      (id),
      .yumi_i    (yumi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  v;
      logic [47:0] op0;
      logic [47:0] op1;
      logic        yumi;
      logic [1:0]  e_ready;
      logic        e_v;
      logic [15:0] e_data;
      logic        e_id;
   } vec_t;

   localparam int NumVec = 14;
   vec_t vecs [NumVec];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] vv, input logic [47:0] o0, input logic [47:0] o1,
                        input logic yy);
      v    = vv;
      i0   = {o1[47:32], o0[47:32]};
      i1   = {o1[31:16], o0[31:16]};
      sel  = {o1[15:0],  o0[15:0]};
      yumi = yy;
   endtask

   // yumi while empty is illegal stimulus.
   always @(negedge clk) begin
      if (reset_n && yumi && !v_out) begin
         errors++;
         $display("FAIL yumi_legal: yumi=1 with v_o=%0b at %0t", v_out, $time);
      end
   end

   initial begin
      checks = 0;
      errors = 0;

      // Starts from empty, ptr=0 (state left by the round-robin phase).
      vecs[0]  = '{2'b01, OpA, OpZ, 1'b0, 2'b01, 1'b1, 16'hF00F, 1'b0};
      vecs[1]  = '{2'b00, OpZ, OpZ, 1'b1, 2'b00, 1'b0, 16'hF00F, 1'b0};
      vecs[2]  = '{2'b10, OpZ, OpB, 1'b0, 2'b10, 1'b1, 16'hEDCB, 1'b1};
      vecs[3]  = '{2'b01, OpC, OpZ, 1'b1, 2'b01, 1'b1, 16'h5A5A, 1'b0};
      vecs[4]  = '{2'b11, OpA, OpD, 1'b1, 2'b10, 1'b1, 16'hFF00, 1'b1};
      vecs[5]  = '{2'b11, OpA, OpD, 1'b1, 2'b01, 1'b1, 16'hF00F, 1'b0};
      vecs[6]  = '{2'b11, OpA, OpD, 1'b1, 2'b10, 1'b1, 16'hFF00, 1'b1};
      vecs[7]  = '{2'b11, OpA, OpD, 1'b1, 2'b01, 1'b1, 16'hF00F, 1'b0};
      vecs[8]  = '{2'b11, OpA, OpD, 1'b0, 2'b00, 1'b1, 16'hF00F, 1'b0};
      vecs[9]  = '{2'b11, OpA, OpD, 1'b0, 2'b00, 1'b1, 16'hF00F, 1'b0};
      vecs[10] = '{2'b11, OpA, OpD, 1'b0, 2'b00, 1'b1, 16'hF00F, 1'b0};
      vecs[11] = '{2'b11, OpA, OpD, 1'b1, 2'b10, 1'b1, 16'hFF00, 1'b1};
      vecs[12] = '{2'b00, OpZ, OpZ, 1'b1, 2'b00, 1'b0, 16'hFF00, 1'b1};
      vecs[13] = '{2'b00, OpZ, OpZ, 1'b0, 2'b00, 1'b0, 16'hFF00, 1'b1};

      reset_n = 1'b0;
      drive(2'b00, OpZ, OpZ, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("reset_v_o", 32'(v_out), 32'd0);
      check("reset_data", 32'(data), 32'h0000);
      check("reset_id", 32'(id), 32'd0);
      check("reset_ready", 32'(ready), 32'd0);
      @(posedge clk);
      #1;

      // Both requesters continuously valid, consumer always taking.
      for (int c = 0; c < 4; c++) begin
         drive(2'b11, OpA, OpD, v_out);
         #1;
         check("rr_ready", 32'(ready), (c % 2 == 0) ? 32'd1 : 32'd2);
         @(posedge clk);
         #1;
         check("rr_v_o", 32'(v_out), 32'd1);
         check("rr_id", 32'(id), 32'(c % 2));
         check("rr_data", 32'(data), (c % 2 == 0) ? 32'hF00F : 32'hFF00);
      end
      drive(2'b00, OpZ, OpZ, 1'b1);
      @(posedge clk);
      #1;
      check("drain_v_o", 32'(v_out), 32'd0);

      for (int n = 0; n < NumVec; n++) begin
         drive(vecs[n].v, vecs[n].op0, vecs[n].op1, vecs[n].yumi);
         #1;
         check($sformatf("vec%0d_ready", n), 32'(ready), 32'(vecs[n].e_ready));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_v_o", n), 32'(v_out), 32'(vecs[n].e_v));
         check($sformatf("vec%0d_data", n), 32'(data), 32'(vecs[n].e_data));
         check($sformatf("vec%0d_id", n), 32'(id), 32'(vecs[n].e_id));
      end

      // Fill with id=1 (ptr wraps to 0), then reset between edges.
      drive(2'b10, OpZ, OpD, 1'b0);
      #1;
      check("midrst_fill_ready", 32'(ready), 32'd2);
      @(posedge clk);
      #1;
      check("midrst_fill_v_o", 32'(v_out), 32'd1);
      check("midrst_fill_id", 32'(id), 32'd1);
      drive(2'b00, OpZ, OpZ, 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_async_v_o", 32'(v_out), 32'd0);
      check("midrst_async_data", 32'(data), 32'h0000);
      check("midrst_async_id", 32'(id), 32'd0);
      #1;
      reset_n = 1'b1;
      drive(2'b11, OpA, OpD, 1'b0);
      #1;
      check("midrst_first_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      check("midrst_first_v_o", 32'(v_out), 32'd1);
      check("midrst_first_id", 32'(id), 32'd0);
      check("midrst_first_data", 32'(data), 32'hF00F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_muxi2_arb_sched.md
# bsg_muxi2_arb_sched

Round-robin scheduler that shares one inverting per-bit 2:1 mux datapath among `els_p` requesters. Each requester offers an operand triple: `i0`, `i1`, and a per-bit select. The granted triple is evaluated as `~(sel ? i1 : i0)` per bit. The result is held in a single-entry registered output buffer with a valid/yumi interface. The block sits in front of the shared muxi2 gatestack and owns its select/operand inputs, so requesters never drive that datapath directly.

## Interface
- `width_p`, default 16: datapath width in bits.
- `els_p`, default 2: number of requesters. Legal range is 2..8.
- `lg_els_lp`, derived `$clog2(els_p)`: requester id width. Not overridable.

- `clk_i` in 1: the single clock. All state updates on its rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset. Assertion clears state immediately; release is synchronous to `clk_i` by the system.
- `v_i` in `els_p`: per-requester request valid.
- `i0_i` in `els_p*width_p`: operand 0 (select = 0) for requester k, at bits `[k*width_p +: width_p]`.
- `i1_i` in `els_p*width_p`: operand 1 (select = 1), same packing.
- `sel_i` in `els_p*width_p`: per-bit select, same packing.
- `ready_o` out `els_p`: one-hot accept. Requester k transfers when `v_i[k] & ready_o[k]`.
- `v_o` out 1: output buffer holds a result.
- `data_o` out `width_p`: registered result.
- `id_o` out `lg_els_lp`: index of the requester that produced `data_o`.
- `yumi_i` in 1: consumer takes `data_o` this cycle. Legal only when `v_o=1`.

## Operation
- Output buffer FSM has two states:
  - EMPTY (`v_o=0`).
  - FULL (`v_o=1`).
- Accept enable: `acc_en = ~v_o | yumi_i`. This allows a same-cycle drain and refill.
- Arbitration:
  - Priority pointer `ptr_r` (`lg_els_lp` bits) names the highest-priority requester.
  - The grant goes to the first valid requester scanning `ptr_r`, `ptr_r+1`, … modulo `els_p`.
  - At most one grant per cycle.
- `ready_o[k] = grant[k] & acc_en`. `ready_o` is combinational from `v_i`, `v_o` and `yumi_i`. With no valid requester, `ready_o=0`.
- On transfer from requester k:
  - `data_o <= ~((sel_k & i1_k) | (~sel_k & i0_k))`, bitwise over `width_p`.
  - `id_o <= k`.
  - `v_o <= 1`.
  - `ptr_r <= (k+1) mod els_p`. The modulo wrap applies for non-power-of-2 `els_p`.
- `yumi_i` without a transfer in the same cycle: `v_o <= 0`. `data_o` and `id_o` hold their last values.
- Without transfer or yumi: all state holds. `data_o` and `id_o` are stable while FULL.
- `ptr_r` advances only on a transfer. Idle cycles and backpressure cycles do not move it.
- `yumi_i` while `v_o=0` is illegal. The bench asserts against it; the RTL ignores it.
- Requesters may drop `v_i` without transfer. There is no commitment; arbitration is re-evaluated every cycle.

## Timing
- Reset values: `v_o=0`, `data_o=0`, `id_o=0`, `ptr_r=0`, so `ready_o=0`. Reset takes effect asynchronously on `reset_n_i` falling, without a clock edge.
- Reset mid-operation: a held result is discarded and not delivered. After release, requester 0 has highest priority.
- Latency: a transfer in cycle n gives `v_o=1` and `data_o` valid in cycle n+1.
- Throughput: one result per cycle when `yumi_i` is asserted every cycle `v_o=1`.
- Fairness: with all `els_p` requesters continuously valid and no backpressure, grants rotate 0,1,…,`els_p`-1,0,…. Each requester waits at most `els_p`-1 transfers.
- No combinational path from `v_i` or operands to `v_o`, `data_o` or `id_o`.

## Test plan
- **Reset:** hold `reset_n_i=0` with `v_i=0` and toggle the clock. Then release. Required: `v_o=0`, `data_o=0x0000`, `id_o=0`, `ready_o=2'b00`. Asserting `reset_n_i=0` between edges while FULL drops `v_o` to 0 before the next edge.
- **Single request** (`width_p=16`, `els_p=2`): requester 0 drives `i0=0x00FF`, `i1=0xFF00`, `sel=0x0F0F` in cycle 0. Required: `ready_o=2'b01` in cycle 0; in cycle 1 `v_o=1`, `data_o=0xF00F`, `id_o=0`.
- **Select extremes:** `sel=0xFFFF` with `i1=0x1234` gives `data_o=0xEDCB`. `sel=0x0000` with `i0=0xA5A5` gives `data_o=0x5A5A`.
- **Round-robin:** both requesters valid continuously, `yumi_i=1` whenever `v_o=1`. Required: `ready_o` sequence 01,10,01,10; `id_o` sequence 0,1,0,1 from cycle 1; no idle cycle.
- **Backpressure:** FULL with `yumi_i=0` for 3 cycles while both are valid. Required: `ready_o=00`, `data_o` and `id_o` unchanged, `ptr_r` unchanged. On the cycle `yumi_i=1`, the next-priority requester gets `ready_o` and its result appears the following cycle with `v_o` continuously 1.
- **Reset mid-op:** FULL with `id_o=1` and `ptr_r=0`, then pulse `reset_n_i` low. Required: `v_o=0` immediately. After release with both requesters valid, the first grant is `ready_o=2'b01`.
